estagio_ex_mem_flags: RTL

Sits directly downstream of the ALU and forms the EX/MEM boundary of the ARM-32 datapath. It holds the architectural NZCV flags register (CPSR condition bits) and evaluates the ARM condition field of the instruction in EX against those committed flags. It commits or squashes the ALU result into the EX/MEM pipeline register, and updates the flags under control of the S bit. It also keeps a saturating count of condition-squashed instructions for debug.

---
 rtl/estagio_ex_mem_flags_pkg.sv | 35 +++
 rtl/estagio_ex_mem_flags_avaliador_condicao.sv | 45 ++++
 rtl/estagio_ex_mem_flags.sv | 87 ++++++++
 3 files changed

// File: rtl/estagio_ex_mem_flags_pkg.sv
// rtl/estagio_ex_mem_flags_pkg.sv - shared constants for the EX/MEM flags stage
// Purpose: ARM condition codes, NZCV bit positions and default data width,
// shared by the EX/MEM stage and the condition evaluator (also usable by the
// branch unit).
package estagio_ex_mem_flags_pkg;

  localparam int LARGURA_DADO_PADRAO = 32;

  // Bit positions inside the {N,Z,C,V} flags word
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // ARM condition field encodings (instruction bits [31:28])
  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

endpackage

// File: rtl/estagio_ex_mem_flags_avaliador_condicao.sv
// rtl/estagio_ex_mem_flags_avaliador_condicao.sv - ARM condition-field evaluator
// Purpose: purely combinational check of a 4-bit ARM condition against NZCV.
// Ports:
//   cond  in  4  condition field
//   flags in  4  {N,Z,C,V}
//   pass  out 1  condition satisfied
module avaliador_condicao
  import estagio_ex_mem_flags_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/estagio_ex_mem_flags.sv
// rtl/estagio_ex_mem_flags.sv - EX/MEM boundary with NZCV flags and condition squash
// Purpose: evaluates the EX instruction's condition against the committed
// flags, commits or squashes the ALU result into the EX/MEM register, updates
// NZCV under the S bit and counts condition-squashed instructions.
// Ports:
//   Clock, Reset (async, active-high)
//   EX side : ValidoEX, Cond, SetFlags, FlagsNZSomente, SaidaULA, NovasFlags,
//             RegDestino, EscreveReg, Stall, Flush
//   outputs : ProntoEX, Executa (comb), Flags, ResultadoMEM, RegDestinoMEM,
//             EscreveRegMEM, ValidoMEM, ContadorAnulados
module estagio_ex_mem_flags
  import estagio_ex_mem_flags_pkg::*;
#(
  parameter int LARGURA_DADO = LARGURA_DADO_PADRAO,
  parameter int LARGURA_REG  = 4,
  parameter int LARGURA_CONT = 16
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    ValidoEX,
  input  logic [3:0]              Cond,
  input  logic                    SetFlags,
  input  logic                    FlagsNZSomente,
  input  logic [LARGURA_DADO-1:0] SaidaULA,
  input  logic [3:0]              NovasFlags,
  input  logic [LARGURA_REG-1:0]  RegDestino,
  input  logic                    EscreveReg,
  input  logic                    Stall,
  input  logic                    Flush,
  output logic                    ProntoEX,
  output logic                    Executa,
  output logic [3:0]              Flags,
  output logic [LARGURA_DADO-1:0] ResultadoMEM,
  output logic [LARGURA_REG-1:0]  RegDestinoMEM,
  output logic                    EscreveRegMEM,
  output logic                    ValidoMEM,
  output logic [LARGURA_CONT-1:0] ContadorAnulados
);

  localparam logic [LARGURA_CONT-1:0] CONT_UM  = {{(LARGURA_CONT-1){1'b0}}, 1'b1};
  localparam logic [LARGURA_CONT-1:0] CONT_MAX = {LARGURA_CONT{1'b1}};

  logic pass;
  logic avanca;

  avaliador_condicao u_avaliador (
    .cond  (Cond),
    .flags (Flags),
    .pass  (pass)
  );

  assign Executa  = ValidoEX & pass;
  assign ProntoEX = ~Stall | Flush;
  // Normal advance only; Flush has its own branch below
  assign avanca   = ~Stall & ~Flush;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Flags            <= 4'b0000;
      ResultadoMEM     <= '0;
      RegDestinoMEM    <= '0;
      EscreveRegMEM    <= 1'b0;
      ValidoMEM        <= 1'b0;
      ContadorAnulados <= '0;
    end else if (Flush) begin
      ValidoMEM     <= 1'b0;
      EscreveRegMEM <= 1'b0;
    end else if (avanca) begin
      ValidoMEM     <= Executa;
      EscreveRegMEM <= Executa & EscreveReg;
      if (Executa) begin
        ResultadoMEM  <= SaidaULA;
        RegDestinoMEM <= RegDestino;
        if (SetFlags) begin
          // Logical ops only define N,Z; C,V keep their committed values
          if (FlagsNZSomente)
            Flags <= {NovasFlags[FLAG_N:FLAG_Z], Flags[FLAG_C:FLAG_V]};
          else
            Flags <= NovasFlags;
        end
      end
      if (ValidoEX && !Executa && ContadorAnulados != CONT_MAX)
        ContadorAnulados <= ContadorAnulados + CONT_UM;
    end
  end

endmodule
